// File: rtl/ad9653_spi_pkg.sv
// Shared definitions for the AD9653-style SPI register responder:
// instruction layout, FSM encoding and the default chip identifier.
package ad9653_spi_pkg;

    localparam int ADDR_W  = 13;
    localparam int INSTR_W = 16;
    localparam int RW_BIT  = 15;
    localparam int W1_BIT  = 14;
    localparam int W0_BIT  = 13;

    localparam logic [7:0] CHIP_ID_DEFAULT = 8'h73;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INSTR = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Field order mirrors the wire order: R/W, W1W0, then the start address.
    typedef struct packed {
        logic              rd;
        logic [1:0]        w;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    function automatic instr_t instr_decode(input logic [INSTR_W-1:0] word);
        return instr_t'(word);
    endfunction

    // Streaming walks downward and wraps 0x0000 -> 0x1FFF.
    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a);
        return a - 13'd1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives the
// sclk edges and the chip-select falling edge from the synchronized copies.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic csb,
    input  logic sdio,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_fall,
    output logic csb_high,
    output logic sdio_sync
);

    logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic       csb_meta_r, csb_sync_r, csb_prev_r;
    logic       sdio_meta_r, sdio_sync_r;
    logic [1:0] vld_r;
    logic       armed_r;

    // Two-stage synchronizers, edge history and post-reset arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            csb_meta_r  <= 1'b1;
            csb_sync_r  <= 1'b1;
            csb_prev_r  <= 1'b1;
            sdio_meta_r <= 1'b0;
            sdio_sync_r <= 1'b0;
            vld_r       <= 2'b00;
            armed_r     <= 1'b0;
        end else begin
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            csb_meta_r  <= csb;
            csb_sync_r  <= csb_meta_r;
            csb_prev_r  <= csb_sync_r;
            sdio_meta_r <= sdio;
            sdio_sync_r <= sdio_meta_r;
            vld_r       <= {vld_r[0], 1'b1};
            // The reset value of the csb chain is not a real observation; only a
            // genuine high seen on the pin may precede a transfer-starting fall.
            armed_r     <= armed_r | (vld_r[1] & csb_sync_r);
        end
    end

    assign sclk_rise = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall = ~sclk_sync_r & sclk_prev_r;
    assign csb_fall  = armed_r & csb_prev_r & ~csb_sync_r;
    assign csb_high  = csb_sync_r;
    assign sdio_sync = sdio_sync_r;

endmodule

// File: rtl/ad9653_spi_responder.sv
// 3-wire SPI slave emulating the AD9653 register port: 16-bit instruction,
// 1..4 streamed data bytes with descending address, small register file.
module ad9653_spi_responder
    import ad9653_spi_pkg::*;
#(
    parameter logic [7:0] CHIP_ID = CHIP_ID_DEFAULT,
    parameter int         NREG    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_csb,
    input  logic              spi_sdio_in,
    output logic              spi_sdio_out,
    output logic              spi_sdio_oe,
    output logic [8*NREG-1:0] reg_flat,
    output logic              reg_we,
    output logic [12:0]       reg_waddr,
    output logic [7:0]        reg_wdata
);

    logic sclk_rise_s, sclk_fall_s, csb_fall_s, csb_high_s, sdio_s;

    logic [1:0]        state_r;
    logic [3:0]        bit_cnt_r;
    logic [14:0]       instr_sr_r;
    logic [6:0]        rx_sr_r;
    logic [7:0]        tx_sr_r;
    logic              rd_r;
    logic              rd_last_r;
    logic [1:0]        bytes_left_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        regs_r [NREG];

    instr_t            instr_s;
    logic [7:0]        byte_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [7:0]        rd_start_raw_s, rd_next_raw_s, rd_start_s, rd_next_s;
    logic              commit_s, wr_ok_s;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi_sclk),
        .csb       (spi_csb),
        .sdio      (spi_sdio_in),
        .sclk_rise (sclk_rise_s),
        .sclk_fall (sclk_fall_s),
        .csb_fall  (csb_fall_s),
        .csb_high  (csb_high_s),
        .sdio_sync (sdio_s)
    );

    assign instr_s     = instr_decode({instr_sr_r, sdio_s});
    assign byte_s      = {rx_sr_r, sdio_s};
    assign addr_next_s = addr_step(addr_r);
    assign wr_ok_s     = (addr_r < ADDR_W'(NREG)) && (addr_r != 13'h001);
    assign commit_s    = !csb_high_s && (state_r == ST_DATA) && !rd_r
                         && sclk_rise_s && (bit_cnt_r == 4'd7);

    // Read muxes for the first byte (from the instruction) and the next streamed byte.
    always_comb begin
        rd_start_raw_s = 8'h00;
        rd_next_raw_s  = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            rd_start_raw_s = rd_start_raw_s | ((instr_s.addr == ADDR_W'(i)) ? regs_r[i] : 8'h00);
            rd_next_raw_s  = rd_next_raw_s  | ((addr_next_s  == ADDR_W'(i)) ? regs_r[i] : 8'h00);
        end
        rd_start_s = (instr_s.addr == 13'h001) ? CHIP_ID : rd_start_raw_s;
        rd_next_s  = (addr_next_s  == 13'h001) ? CHIP_ID : rd_next_raw_s;
    end

    // Transfer FSM: instruction shift-in, write byte assembly, read shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 4'd0;
            instr_sr_r   <= 15'h0000;
            rx_sr_r      <= 7'h00;
            tx_sr_r      <= 8'h00;
            rd_r         <= 1'b0;
            rd_last_r    <= 1'b0;
            bytes_left_r <= 2'd0;
            addr_r       <= 13'h0000;
            spi_sdio_out <= 1'b0;
            spi_sdio_oe  <= 1'b0;
        end else if (csb_high_s) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 4'd0;
            rd_last_r    <= 1'b0;
            spi_sdio_out <= 1'b0;
            spi_sdio_oe  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (csb_fall_s) begin
                        state_r   <= ST_INSTR;
                        bit_cnt_r <= 4'd0;
                    end
                end
                ST_INSTR: begin
                    if (sclk_rise_s) begin
                        instr_sr_r <= {instr_sr_r[13:0], sdio_s};
                        if (bit_cnt_r == 4'd15) begin
                            state_r      <= ST_DATA;
                            bit_cnt_r    <= 4'd0;
                            rd_r         <= instr_s.rd;
                            bytes_left_r <= instr_s.w;
                            addr_r       <= instr_s.addr;
                            tx_sr_r      <= rd_start_s;
                            rd_last_r    <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rd_r && sclk_fall_s) begin
                        // The fall after the last bit closes the final bit cell.
                        if (rd_last_r) begin
                            state_r     <= ST_DONE;
                            spi_sdio_oe <= 1'b0;
                        end else begin
                            spi_sdio_oe  <= 1'b1;
                            spi_sdio_out <= tx_sr_r[7];
                            tx_sr_r      <= {tx_sr_r[6:0], 1'b0};
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                if (bytes_left_r == 2'd0) begin
                                    rd_last_r <= 1'b1;
                                end else begin
                                    bytes_left_r <= bytes_left_r - 2'd1;
                                    addr_r       <= addr_next_s;
                                    tx_sr_r      <= rd_next_s;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end else if (!rd_r && sclk_rise_s) begin
                        rx_sr_r <= byte_s[6:0];
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_r <= 4'd0;
                            addr_r    <= addr_next_s;
                            if (bytes_left_r == 2'd0) begin
                                state_r <= ST_DONE;
                            end else begin
                                bytes_left_r <= bytes_left_r - 2'd1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file and the committed-write strobe; read-only and absent addresses still strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
            reg_we    <= 1'b0;
            reg_waddr <= 13'h0000;
            reg_wdata <= 8'h00;
        end else begin
            reg_we <= commit_s;
            if (commit_s) begin
                reg_waddr <= addr_r;
                reg_wdata <= byte_s;
            end
            for (int i = 0; i < NREG; i++) begin
                if (commit_s && wr_ok_s && (addr_r == ADDR_W'(i))) begin
                    regs_r[i] <= byte_s;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign reg_flat[8*g +: 8] = regs_r[g];
    end

endmodule

// File: tb/tb_ad9653_spi_responder.sv
// Directed bench for ad9653_spi_responder: a vector table of SPI transfers
// with hand-computed results, plus abort and reset-during-read sequences.
module tb_ad9653_spi_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         spi_sclk, spi_csb, spi_sdio_in;
    logic         spi_sdio_out, spi_sdio_oe;
    logic [127:0] reg_flat;
    logic         reg_we;
    logic [12:0]  reg_waddr;
    logic [7:0]   reg_wdata;

    int          n_vec = 0;
    int          n_bad = 0;
    int          we_cnt = 0;
    int          oe_wr_hits = 0;
    logic        wr_active = 1'b0;
    logic [12:0] last_waddr = 13'h0;
    logic [7:0]  last_wdata = 8'h0;

    typedef struct {
        logic [15:0]  instr;
        int           nbytes;
        logic [31:0]  wdata;     // right-aligned, first byte most significant
        int           exp_we;
        logic [12:0]  exp_waddr; // last committed write
        logic [7:0]   exp_wdata;
        logic [31:0]  exp_rd;    // right-aligned, first byte most significant
        logic [127:0] exp_flat;
    } vec_t;

    vec_t vecs[11];

    ad9653_spi_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_csb      (spi_csb),
        .spi_sdio_in  (spi_sdio_in),
        .spi_sdio_out (spi_sdio_out),
        .spi_sdio_oe  (spi_sdio_oe),
        .reg_flat     (reg_flat),
        .reg_we       (reg_we),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt     = we_cnt + 1;
            last_waddr = reg_waddr;
            last_wdata = reg_wdata;
        end
        if (wr_active && spi_sdio_oe) oe_wr_hits = oe_wr_hits + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sclk period of 10 clk: drive data while low, sample SDIO just before rising.
    task automatic spi_bit(input logic din, output logic dout, output logic doe);
        spi_sdio_in = din;
        repeat (5) @(negedge clk);
        dout = spi_sdio_out;
        doe  = spi_sdio_oe;
        spi_sclk = 1'b1;
        repeat (5) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_open();
        spi_csb = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic spi_close();
        repeat (2) @(negedge clk);
        spi_csb = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_xfer(input logic [15:0] instr, input int nbytes, input logic [31:0] wdata,
                            output logic [31:0] rd, output int oe_cnt);
        logic d, o;
        rd = 32'h0;
        oe_cnt = 0;
        spi_open();
        for (int i = 15; i >= 0; i--) begin
            spi_bit(instr[i], d, o);
            if (o) oe_cnt++;
        end
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 7; k >= 0; k--) begin
                spi_bit(wdata[8*(nbytes-1-b) + k], d, o);
                rd = {rd[30:0], d};
                if (o) oe_cnt++;
            end
        end
        spi_close();
    endtask

    initial begin
        logic [31:0] rd;
        logic        d, o;
        int          oe_cnt;
        logic [127:0] flat_before;

        rst_n = 1'b0;
        spi_csb = 1'b1;
        spi_sclk = 1'b0;
        spi_sdio_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flat", reg_flat, 128'h0);
        chk("reset_oe", spi_sdio_oe, 1'b0);
        chk("reset_out", spi_sdio_out, 1'b0);
        chk("reset_we", reg_we, 1'b0);
        chk("reset_waddr", reg_waddr, 13'h0);
        chk("reset_wdata", reg_wdata, 8'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        vecs[0]  = '{16'h0005, 1, 32'h000000A5, 1, 13'h005, 8'hA5, 32'h0,
                     128'h00000000000000000000A50000000000};
        vecs[1]  = '{16'h6003, 4, 32'h11223344, 4, 13'h000, 8'h44, 32'h0,
                     128'h00000000000000000000A50011220044};
        vecs[2]  = '{16'h8001, 1, 32'h0, 0, 13'h0, 8'h0, 32'h00000073,
                     128'h00000000000000000000A50011220044};
        vecs[3]  = '{16'h8003, 1, 32'h0, 0, 13'h0, 8'h0, 32'h00000011,
                     128'h00000000000000000000A50011220044};
        vecs[4]  = '{16'hE005, 4, 32'h0, 0, 13'h0, 8'h0, 32'hA5001122,
                     128'h00000000000000000000A50011220044};
        vecs[5]  = '{16'h0000, 1, 32'h0000005A, 1, 13'h000, 8'h5A, 32'h0,
                     128'h00000000000000000000A5001122005A};
        vecs[6]  = '{16'hA000, 2, 32'h0, 0, 13'h0, 8'h0, 32'h00005A00,
                     128'h00000000000000000000A5001122005A};
        vecs[7]  = '{16'h0010, 1, 32'h000000FF, 1, 13'h010, 8'hFF, 32'h0,
                     128'h00000000000000000000A5001122005A};
        vecs[8]  = '{16'h000F, 1, 32'h000000C3, 1, 13'h00F, 8'hC3, 32'h0,
                     128'hC3000000000000000000A5001122005A};
        vecs[9]  = '{16'h800F, 1, 32'h0, 0, 13'h0, 8'h0, 32'h000000C3,
                     128'hC3000000000000000000A5001122005A};
        vecs[10] = '{16'h2001, 2, 32'h00009977, 2, 13'h000, 8'h77, 32'h0,
                     128'hC3000000000000000000A50011220077};

        for (int v = 0; v < 11; v++) begin
            we_cnt = 0;
            oe_wr_hits = 0;
            wr_active = !vecs[v].instr[15];
            run_xfer(vecs[v].instr, vecs[v].nbytes, vecs[v].wdata, rd, oe_cnt);
            wr_active = 1'b0;
            chk($sformatf("v%0d_we_count", v), we_cnt, vecs[v].exp_we);
            chk($sformatf("v%0d_flat", v), reg_flat, vecs[v].exp_flat);
            chk($sformatf("v%0d_oe_after", v), spi_sdio_oe, 1'b0);
            if (vecs[v].instr[15]) begin
                chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
                chk($sformatf("v%0d_oe_bits", v), oe_cnt, 8 * vecs[v].nbytes);
            end else begin
                chk($sformatf("v%0d_oe_write", v), oe_wr_hits, 0);
                chk($sformatf("v%0d_waddr", v), last_waddr, vecs[v].exp_waddr);
                chk($sformatf("v%0d_wdata", v), last_wdata, vecs[v].exp_wdata);
            end
        end

        // Abort: write to 0x004 dropped after 5 data bits.
        flat_before = reg_flat;
        we_cnt = 0;
        spi_open();
        for (int i = 15; i >= 0; i--) spi_bit(i == 2, d, o);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, d, o);
        spi_close();
        chk("abort_we_count", we_cnt, 0);
        chk("abort_flat", reg_flat, flat_before);
        we_cnt = 0;
        run_xfer(16'h0004, 1, 32'h3C, rd, oe_cnt);
        chk("after_abort_we_count", we_cnt, 1);
        chk("after_abort_reg4", reg_flat[39:32], 8'h3C);

        // Reset in the middle of the first read byte.
        spi_open();
        for (int i = 15; i >= 0; i--) spi_bit((i == 15) || (i == 2) || (i == 0), d, o);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, d, o);
        chk("midread_oe_active", o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midread_rst_oe", spi_sdio_oe, 1'b0);
        chk("midread_rst_flat", reg_flat, 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        we_cnt = 0;
        oe_cnt = 0;
        // csb never went high after reset, so this clocking must be ignored.
        for (int i = 0; i < 24; i++) begin
            spi_bit(1'b0, d, o);
            if (o) oe_cnt++;
        end
        chk("post_rst_idle_we", we_cnt, 0);
        chk("post_rst_idle_oe", oe_cnt, 0);
        spi_close();
        run_xfer(16'h8001, 1, 32'h0, rd, oe_cnt);
        chk("post_rst_read_id", rd, 32'h73);
        chk("post_rst_read_oe", oe_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
